// File: rtl/sampler_voice_sequencer_pkg.sv
// Shared state encoding, per-voice pointer record and width constants for the
// polyphonic sampler voice sequencer.
package sampler_pkg;

  localparam int SMP_NUM_VOICES = 4;
  localparam int SMP_ADDR_W     = 20;
  localparam int SMP_LEN_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic                  active;
    logic                  loop;
    logic [SMP_ADDR_W-1:0] base;
    logic [SMP_ADDR_W-1:0] addr;
    logic [SMP_LEN_W-1:0]  len;
    logic [SMP_LEN_W-1:0]  len_reload;
  } voice_t;

  // Voice index width, never narrower than one bit.
  function automatic int vidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sampler_voice_sequencer_voice.sv
// One sample-playback pointer. A new note beats a stop, which beats an advance;
// the pointer steps only when the sequencer reports an accepted read.
module sampler_voice
  import sampler_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load_i,
  input  logic [SMP_ADDR_W-1:0] base_i,
  input  logic [SMP_LEN_W-1:0]  len_i,
  input  logic                  loop_i,
  input  logic                  stop_i,
  input  logic                  advance_i,
  output logic                  active_o,
  output logic [SMP_ADDR_W-1:0] addr_o
);

  voice_t voice_q, voice_d;

  always_comb begin
    voice_d = voice_q;
    if (load_i) begin
      voice_d.active     = 1'b1;
      voice_d.loop       = loop_i;
      voice_d.base       = base_i;
      voice_d.addr       = base_i;
      voice_d.len        = len_i;
      voice_d.len_reload = len_i;
    end else if (stop_i) begin
      voice_d.active = 1'b0;
    end else if (advance_i && voice_q.active) begin
      voice_d.addr = voice_q.addr + 1'b1;
      voice_d.len  = voice_q.len - 1'b1;
      // Last sample of the note: either rewind to the start or fall silent.
      if (voice_q.len == SMP_LEN_W'(1)) begin
        if (voice_q.loop) begin
          voice_d.addr = voice_q.base;
          voice_d.len  = voice_q.len_reload;
        end else begin
          voice_d.active = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      voice_q <= '0;
    end else begin
      voice_q <= voice_d;
    end
  end

  assign active_o = voice_q.active;
  assign addr_o   = voice_q.addr;

endmodule

// File: rtl/sampler_voice_sequencer.sv
// Polyphonic sample-address sequencer: each sample_clk tick visits every voice once
// (one cycle per voice when rd_ready is high) and issues one held, never-retracted read per active voice.
module sampler_voice_sequencer
  import sampler_pkg::*;
#(
  parameter int  NUM_VOICES = SMP_NUM_VOICES,
  parameter int  ADDR_W     = SMP_ADDR_W,
  parameter int  LEN_W      = SMP_LEN_W,
  localparam int VIDX_W     = vidx_width(NUM_VOICES)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  sample_clk,
  input  logic                  note_on,
  input  logic [VIDX_W-1:0]     note_voice,
  input  logic [ADDR_W-1:0]     note_base,
  input  logic [LEN_W-1:0]      note_len,
  input  logic                  note_loop,
  input  logic                  note_off,
  input  logic [VIDX_W-1:0]     off_voice,
  output logic                  rd_valid,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [VIDX_W-1:0]     rd_voice,
  input  logic                  rd_ready,
  output logic                  frame_done,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  overrun
);

  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

  seq_state_e            state_q, state_d;
  logic [VIDX_W-1:0]     vidx_q, vidx_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  hit_q, hit_d;
  logic                  overrun_q, overrun_d;
  logic                  enter;
  logic [VIDX_W-1:0]     enter_idx;
  logic                  advance;
  logic                  note_valid;
  logic [NUM_VOICES-1:0] load_vec, stop_vec, touch_vec, adv_vec;
  logic [ADDR_W-1:0]     voice_addr [NUM_VOICES];

  assign note_valid = note_on && (note_len != '0);

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    assign load_vec[i] = note_valid && (note_voice == VIDX_W'(i));
    assign stop_vec[i] = note_off && (off_voice == VIDX_W'(i));
    assign adv_vec[i]  = advance && (vidx_q == VIDX_W'(i));

    sampler_voice u_voice (
      .Clk       (Clk),
      .Reset     (Reset),
      .load_i    (load_vec[i]),
      .base_i    (note_base),
      .len_i     (note_len),
      .loop_i    (note_loop),
      .stop_i    (stop_vec[i]),
      .advance_i (adv_vec[i]),
      .active_o  (voice_active[i]),
      .addr_o    (voice_addr[i])
    );
  end

  assign touch_vec = load_vec | stop_vec;

  always_comb begin
    state_d   = state_q;
    vidx_d    = vidx_q;
    rd_addr_d = rd_addr_q;
    hit_d     = hit_q;
    advance   = 1'b0;
    enter     = 1'b0;
    enter_idx = '0;
    overrun_d = overrun_q | (sample_clk && (state_q != IDLE));

    case (state_q)
      IDLE: enter = sample_clk;
      SCAN: begin
        if (vidx_q == LAST_V) begin
          state_d = DONE;
        end else begin
          enter     = 1'b1;
          enter_idx = vidx_q + 1'b1;
        end
      end
      ISSUE: begin
        if (rd_ready) begin
          // A note_on/note_off that landed on this voice while its read was
          // pending owns the pointer now, so the accept must not move it.
          advance = !hit_q;
          if (vidx_q == LAST_V) begin
            state_d = DONE;
          end else begin
            enter     = 1'b1;
            enter_idx = vidx_q + 1'b1;
          end
        end else begin
          hit_d = hit_q | touch_vec[vidx_q];
        end
      end
      DONE: begin
        state_d = IDLE;
        vidx_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // Voice selection is decided on entry so each visit costs exactly one cycle.
    if (enter) begin
      vidx_d = enter_idx;
      if (voice_active[enter_idx]) begin
        state_d   = ISSUE;
        rd_addr_d = voice_addr[enter_idx];
        hit_d     = touch_vec[enter_idx];
      end else begin
        state_d = SCAN;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      vidx_q    <= '0;
      rd_addr_q <= '0;
      hit_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vidx_q    <= vidx_d;
      rd_addr_q <= rd_addr_d;
      hit_q     <= hit_d;
      overrun_q <= overrun_d;
    end
  end

  assign rd_valid   = (state_q == ISSUE);
  assign rd_addr    = rd_addr_q;
  assign rd_voice   = vidx_q;
  assign frame_done = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule
